// File: rtl/rtc_seg_pkg.sv
// Shared constants and helpers for the 7-segment display path
// (used by rtc_displaydriver and rtc_seg_scanner).
package rtc_seg_pkg;

    localparam int              SEG_W      = 8;
    localparam logic [SEG_W-1:0] SEG_ALL_ON = 8'hFF;
    localparam int              SEG_DP_BIT = 7;

    // Internal patterns are active-high; this maps them to pin polarity.
    function automatic logic [SEG_W-1:0] apply_polarity(input logic [SEG_W-1:0] val,
                                                        input bit               act_low);
        return act_low ? ~val : val;
    endfunction

endpackage

// File: rtl/rtc_seg_scanner_if.sv
// Signal bundle between the digit-pattern source and the scan driver.
interface rtc_seg_scanner_if #(
    parameter int NUM_DIGITS = 6,
    parameter int BRIGHT_W   = 2
);
    import rtc_seg_pkg::*;

    localparam int SLOT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    // No handshake: inputs are levels sampled once per digit slot, outputs are registered pins.
    logic [SEG_W*NUM_DIGITS-1:0] i_seg_data;
    logic [NUM_DIGITS-1:0]       i_dp_mask;
    logic [NUM_DIGITS-1:0]       i_digit_en;
    logic [BRIGHT_W-1:0]         i_bright;
    logic                        i_lamp_test;
    logic [SEG_W-1:0]            o_segments;
    logic [NUM_DIGITS-1:0]       o_anodes;
    logic [SLOT_W-1:0]           o_slot;
    logic                        o_frame_strb;

    modport master (
        output i_seg_data, i_dp_mask, i_digit_en, i_bright, i_lamp_test,
        input  o_segments, o_anodes, o_slot, o_frame_strb
    );

    modport slave (
        input  i_seg_data, i_dp_mask, i_digit_en, i_bright, i_lamp_test,
        output o_segments, o_anodes, o_slot, o_frame_strb
    );

endinterface

// File: rtl/rtc_scan_timer.sv
// Slot timer: cycle counter within a digit slot and digit index, with
// slot-start and frame-wrap strobes.
module rtc_scan_timer #(
    parameter int NUM_DIGITS = 6,
    parameter int SCAN_DIV   = 16,
    parameter int CNT_W      = 4,
    parameter int IDX_W      = 3
) (
    input  logic             i_sclk,
    input  logic             i_reset,
    output logic [CNT_W-1:0] o_cnt,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_slot_start,
    output logic             o_frame_wrap
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             wrap_q, wrap_d;

    always_comb begin
        cnt_d  = cnt_q + CNT_W'(1);
        idx_d  = idx_q;
        wrap_d = 1'b0;
        if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
            cnt_d = '0;
            if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
                idx_d  = '0;
                wrap_d = 1'b1;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge i_sclk) begin
        if (i_reset) begin
            cnt_q  <= '0;
            idx_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            wrap_q <= wrap_d;
        end
    end

    // wrap_q is high during cnt 0 of digit 0 only after a genuine wrap, never after reset.
    assign o_cnt        = cnt_q;
    assign o_idx        = idx_q;
    assign o_slot_start = (cnt_q == '0);
    assign o_frame_wrap = wrap_q;

endmodule

// File: rtl/rtc_seg_scanner.sv
// Time-multiplexed N-digit 7-segment scan driver with per-digit enable, DP mask,
// anti-ghost blanking, PWM brightness, lamp test and selectable pin polarity.
module rtc_seg_scanner
    import rtc_seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 6,
    parameter int SCAN_DIV     = 16,
    parameter int BLANK_CYCLES = 2,
    parameter int BRIGHT_W     = 2,
    parameter bit SEG_ACT_LOW  = 1'b1,
    parameter bit AN_ACT_LOW   = 1'b1
) (
    input  logic             i_sclk,
    input  logic             i_reset,
    rtc_seg_scanner_if.slave bus
);

    localparam int CNT_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int ON_W   = $clog2(SCAN_DIV + 1);
    localparam int ACTIVE = SCAN_DIV - BLANK_CYCLES;

    localparam logic [SEG_W-1:0]      SEG_IDLE = SEG_ACT_LOW ? SEG_ALL_ON : '0;
    localparam logic [NUM_DIGITS-1:0] AN_IDLE  = AN_ACT_LOW ? {NUM_DIGITS{1'b1}} : '0;

    logic [CNT_W-1:0]      cnt;
    logic [IDX_W-1:0]      idx;
    logic                  slot_start;
    logic                  frame_wrap;

    logic [SEG_W-1:0]      sel_pat;
    logic [SEG_W-1:0]      pat_q, pat_d;
    logic                  en_q, en_d;
    logic [ON_W-1:0]       on_len_q, on_len_d;
    logic                  lit;
    logic [NUM_DIGITS-1:0] an_raw;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [SEG_W-1:0]      seg_q, seg_d;
    logic [IDX_W-1:0]      slot_q, slot_d;
    logic                  strb_q, strb_d;

    rtc_scan_timer #(
        .NUM_DIGITS (NUM_DIGITS),
        .SCAN_DIV   (SCAN_DIV),
        .CNT_W      (CNT_W),
        .IDX_W      (IDX_W)
    ) u_timer (
        .i_sclk       (i_sclk),
        .i_reset      (i_reset),
        .o_cnt        (cnt),
        .o_idx        (idx),
        .o_slot_start (slot_start),
        .o_frame_wrap (frame_wrap)
    );

    // Slot inputs are captured during cnt 0; the blanking window hides the stale latch for that cycle.
    always_comb begin
        sel_pat             = bus.i_seg_data[int'(idx)*SEG_W +: SEG_W];
        sel_pat[SEG_DP_BIT] = sel_pat[SEG_DP_BIT] | bus.i_dp_mask[idx];
        pat_d               = pat_q;
        en_d                = en_q;
        on_len_d            = on_len_q;
        if (slot_start) begin
            pat_d    = bus.i_lamp_test ? SEG_ALL_ON : sel_pat;
            en_d     = bus.i_digit_en[idx];
            on_len_d = ON_W'((ACTIVE * (int'(bus.i_bright) + 1)) >> BRIGHT_W);
        end
    end

    always_comb begin
        lit    = en_q && (int'(cnt) >= BLANK_CYCLES)
                      && ((int'(cnt) - BLANK_CYCLES) < int'(on_len_q));
        an_raw = lit ? (NUM_DIGITS'(1) << idx) : '0;
        an_d   = AN_ACT_LOW ? ~an_raw : an_raw;
        seg_d  = apply_polarity(lit ? pat_q : '0, SEG_ACT_LOW);
        slot_d = idx;
        strb_d = frame_wrap;
    end

    always_ff @(posedge i_sclk) begin
        if (i_reset) begin
            pat_q    <= '0;
            en_q     <= 1'b0;
            on_len_q <= '0;
            an_q     <= AN_IDLE;
            seg_q    <= SEG_IDLE;
            slot_q   <= '0;
            strb_q   <= 1'b0;
        end else begin
            pat_q    <= pat_d;
            en_q     <= en_d;
            on_len_q <= on_len_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
            slot_q   <= slot_d;
            strb_q   <= strb_d;
        end
    end

    assign bus.o_segments   = seg_q;
    assign bus.o_anodes     = an_q;
    assign bus.o_slot       = slot_q;
    assign bus.o_frame_strb = strb_q;

endmodule

// File: tb/tb_rtc_seg_scanner.sv
// Bench for rtc_seg_scanner: 4 digits, 16-cycle slots, 2 blank cycles, active-low pins.
module tb_rtc_seg_scanner;

    localparam int ND    = 4;
    localparam int SD    = 16;
    localparam int BL    = 2;
    localparam int BW    = 2;
    localparam int FRAME = ND * SD;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rtc_seg_scanner_if #(.NUM_DIGITS(ND), .BRIGHT_W(BW)) bus ();

    rtc_seg_scanner #(
        .NUM_DIGITS   (ND),
        .SCAN_DIV     (SD),
        .BLANK_CYCLES (BL),
        .BRIGHT_W     (BW),
        .SEG_ACT_LOW  (1'b1),
        .AN_ACT_LOW   (1'b1)
    ) dut (
        .i_sclk  (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model -> expected queue ----------------
    // Entry: {anodes[3:0], segments[7:0], slot[1:0], frame_strb}
    logic [14:0] exp_q[$];
    int          m_t   = 0;
    logic [7:0]  m_pat = '0;
    logic        m_en  = 1'b0;
    int          m_on  = 0;
    int          m_c, m_d;
    logic        m_lit;
    logic [3:0]  m_an;
    logic [7:0]  m_seg, m_raw;

    always @(posedge clk) begin
        if (rst) begin
            exp_q.push_back({4'hF, 8'hFF, 2'd0, 1'b0});
            m_t   = 0;
            m_pat = '0;
            m_en  = 1'b0;
            m_on  = 0;
        end else begin
            m_c   = m_t % SD;
            m_d   = (m_t / SD) % ND;
            m_lit = m_en && (m_c >= BL) && ((m_c - BL) < m_on);
            m_an  = m_lit ? ~(4'b0001 << m_d) : 4'hF;
            m_seg = m_lit ? ~m_pat : 8'hFF;
            exp_q.push_back({m_an, m_seg, 2'(m_d), (m_c == 0 && m_d == 0 && m_t > 0)});
            if (m_c == 0) begin
                m_raw    = bus.i_seg_data[m_d*8 +: 8];
                m_raw[7] = m_raw[7] | bus.i_dp_mask[m_d];
                m_pat    = bus.i_lamp_test ? 8'hFF : m_raw;
                m_en     = bus.i_digit_en[m_d];
                m_on     = ((SD - BL) * (int'(bus.i_bright) + 1)) / (1 << BW);
            end
            m_t++;
        end
    end

    // ---------------- scoreboard / monitor ----------------
    logic [14:0] sb_exp;
    logic [3:0]  prev_an  = 4'hF;
    logic [7:0]  prev_seg = 8'hFF;
    int          cyc       = 0;
    int          last_strb = -1;

    always @(negedge clk) begin
        cyc++;
        if (exp_q.size() > 0) begin
            sb_exp = exp_q.pop_front();
            check("sb", {bus.o_anodes, bus.o_segments, bus.o_slot, bus.o_frame_strb}, sb_exp);
        end
        check("one_anode", 32'($countones(~bus.o_anodes) <= 1), 1);
        if (prev_an != 4'hF && bus.o_anodes != 4'hF)
            check("seg_stable", bus.o_segments, prev_seg);
        if (rst) begin
            last_strb = -1;
        end else if (bus.o_frame_strb) begin
            if (last_strb >= 0) check("strb_period", cyc - last_strb, FRAME);
            last_strb = cyc;
        end
        prev_an  = bus.o_anodes;
        prev_seg = bus.o_segments;
    end

    // ---------------- driver tasks ----------------
    task automatic wait_anode(input logic [3:0] pat, input string tag);
        int n = 0;
        while (bus.o_anodes == pat && n < 200) begin @(negedge clk); n++; end
        while (bus.o_anodes != pat && n < 200) begin @(negedge clk); n++; end
        check({tag, "_found"}, 32'(bus.o_anodes == pat), 1);
    endtask

    task automatic count_lit(input logic [3:0] pat, output int n);
        n = 0;
        repeat (FRAME) begin
            @(negedge clk);
            if (bus.o_anodes == pat) n++;
        end
    endtask

    task automatic first_lit(output int k);
        k = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (bus.o_anodes == 4'hE) begin
                k = i;
                break;
            end
        end
    endtask

    task automatic wait_phase(input int ph, input string tag);
        int n = 0;
        while ((m_t % FRAME) != ph && n < 200) begin @(negedge clk); n++; end
        check({tag, "_phase"}, m_t % FRAME, ph);
    endtask

    // ---------------- stimulus ----------------
    int          k;
    int          lit_n;
    int          bright_seq[3]  = '{1, 0, 2};
    int          bright_cnt[3]  = '{7, 3, 10};

    initial begin
        bus.i_seg_data  = {8'h4F, 8'h5B, 8'h06, 8'h3F};
        bus.i_dp_mask   = 4'b0000;
        bus.i_digit_en  = 4'b1111;
        bus.i_bright    = 2'd3;
        bus.i_lamp_test = 1'b0;

        // reset held 3 cycles
        repeat (3) @(negedge clk);
        check("rst_anodes", bus.o_anodes, 4'hF);
        check("rst_segments", bus.o_segments, 8'hFF);
        check("rst_slot", bus.o_slot, 0);
        check("rst_strb", bus.o_frame_strb, 0);
        rst = 1'b0;

        // first lit output cycle is BLANK+1 of digit 0, full brightness
        first_lit(k);
        check("first_lit", k, BL + 1);
        check("first_seg", bus.o_segments, 8'hC0);
        count_lit(4'hE, lit_n);
        check("lit_bright3", lit_n, 14);

        // brightness codes
        for (int i = 0; i < 3; i++) begin
            bus.i_bright = 2'(bright_seq[i]);
            repeat (2 * FRAME) @(negedge clk);
            count_lit(4'hE, lit_n);
            check($sformatf("lit_bright%0d", bright_seq[i]), lit_n, bright_cnt[i]);
        end
        bus.i_bright = 2'd3;

        // digit 2 disabled
        bus.i_digit_en = 4'b1011;
        repeat (2 * FRAME) @(negedge clk);
        count_lit(4'hB, lit_n);
        check("dig2_off", lit_n, 0);
        count_lit(4'hE, lit_n);
        check("dig0_on", lit_n, 14);
        bus.i_digit_en = 4'b1111;

        // DP mask and lamp test
        bus.i_dp_mask        = 4'b0001;
        bus.i_seg_data[7:0]  = 8'h06;
        repeat (FRAME) @(negedge clk);
        wait_anode(4'hE, "dp");
        check("dp_seg", bus.o_segments, 8'h79);
        bus.i_lamp_test = 1'b1;
        repeat (FRAME) @(negedge clk);
        wait_anode(4'hE, "lamp0");
        check("lamp_seg0", bus.o_segments, 8'h00);
        wait_anode(4'hD, "lamp1");
        check("lamp_seg1", bus.o_segments, 8'h00);
        bus.i_lamp_test      = 1'b0;
        bus.i_dp_mask        = 4'b0000;
        bus.i_seg_data[7:0]  = 8'h3F;
        repeat (2 * FRAME) @(negedge clk);

        // mid-slot data change takes effect only in the next frame
        wait_phase(8, "mid");
        bus.i_seg_data[7:0] = 8'h5B;
        repeat (5) @(negedge clk);
        check("mid_an", bus.o_anodes, 4'hE);
        check("mid_seg_hold", bus.o_segments, 8'hC0);
        wait_anode(4'hE, "next");
        check("next_seg", bus.o_segments, 8'hA4);

        // reset at cnt 10 of slot 2
        repeat (FRAME / 2) @(negedge clk);
        wait_phase(2 * SD + 10, "rst2");
        rst = 1'b1;
        @(negedge clk);
        check("rst2_anodes", bus.o_anodes, 4'hF);
        check("rst2_segments", bus.o_segments, 8'hFF);
        check("rst2_slot", bus.o_slot, 0);
        check("rst2_strb", bus.o_frame_strb, 0);
        @(negedge clk);
        rst = 1'b0;
        first_lit(k);
        check("rst2_first_lit", k, BL + 1);
        check("rst2_restart_slot", bus.o_slot, 0);
        repeat (2 * FRAME) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
